// File: rtl/divider_8bit.sv
// divider_8bit: sequential restoring divider, one shift-subtract-restore step
// per clock. Returns quotient/remainder with a one-cycle done pulse.
// Optional macro DIVIDER_SIGNED_EN: two's complement operands, sign fix-up
// applied when results are loaded, and ovf flags the -128 / -1 case.
module divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;

  logic             accept;
  logic             is_zero;
  logic             last;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  // The guard bit of rem is always zero between steps; it is never read back.
  logic unused_guard;
  assign unused_guard = rem[WIDTH];

  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign is_zero = (divisor == '0);
  assign last    = (count == CW'(WIDTH - 1));

  // One restoring step: shift in the next dividend bit, try the subtract,
  // keep it when no borrow, otherwise restore the shifted value.
  always_comb begin
    shifted  = {rem[WIDTH-1:0], q[WIDTH-1]};
    trial    = shifted - {1'b0, d};
    rem_next = shifted;
    q_next   = {q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next = trial;
      q_next   = {q[WIDTH-2:0], 1'b1};
    end
  end

`ifdef DIVIDER_SIGNED_EN
  logic sign_q;
  logic sign_r;
  logic ovf_pend;
  logic ovf_reg;

  assign op_a    = dividend[WIDTH-1] ? -dividend : dividend;
  assign op_b    = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign q_final = sign_q ? -q_next : q_next;
  assign r_final = sign_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
  assign ovf     = ovf_reg;

  // Remember operand signs and the most-negative / -1 case for the fix-up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      ovf_pend <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (accept) begin
      sign_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sign_r   <= dividend[WIDTH-1];
      ovf_pend <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
      ovf_reg  <= 1'b0;
    end else if ((state == RUN) && last) begin
      ovf_reg  <= ovf_pend;
    end
  end
`else
  assign op_a    = dividend;
  assign op_b    = divisor;
  assign q_final = q_next;
  assign r_final = rem_next[WIDTH-1:0];
  assign ovf     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and status decode; a zero divisor skips straight to DONE.
  always_comb begin
    state_next = state;
    busy       = (state == RUN);
    done       = (state == DONE);
    case (state)
      IDLE, DONE: begin
        if (start) state_next = is_zero ? DONE : RUN;
        else       state_next = IDLE;
      end
      RUN:     if (last) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accepted start, step while running, publish results
  // only on the final step so outputs stay stable during RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem       <= '0;
      q         <= '0;
      d         <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div0      <= 1'b0;
    end else if (accept) begin
      if (is_zero) begin
        quotient  <= '1;
        remainder <= dividend;
        div0      <= 1'b1;
      end else begin
        rem   <= '0;
        q     <= op_a;
        d     <= op_b;
        count <= '0;
        div0  <= 1'b0;
      end
    end else if (state == RUN) begin
      rem   <= rem_next;
      q     <= q_next;
      count <= count + CW'(1);
      if (last) begin
        quotient  <= q_final;
        remainder <= r_final;
      end
    end
  end

endmodule

// File: tb/tb_divider_8bit.sv
// tb_divider_8bit: directed vectors for divider_8bit with hand-computed
// expected values, cycle-exact latency checks and mid-run reset.
module tb_divider_8bit;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div0;
  logic       ovf;

  int checkCount;
  int passCount;

`ifdef DIVIDER_SIGNED_EN
  // 200 is -56 as a signed byte: -56/10 = -5 r -6, -56/3 = -18 r -2.
  localparam logic [7:0] Q200_10 = 8'hFB;
  localparam logic [7:0] R200_10 = 8'hFA;
  localparam logic [7:0] Q200_3  = 8'hEE;
  localparam logic [7:0] R200_3  = 8'hFE;
`else
  localparam logic [7:0] Q200_10 = 8'd20;
  localparam logic [7:0] R200_10 = 8'd0;
  localparam logic [7:0] Q200_3  = 8'd66;
  localparam logic [7:0] R200_3  = 8'd2;
`endif

  divider_8bit #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .div0(div0),
    .ovf(ovf)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one cycle; returns 1 ns into cycle 1.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    nextCycle();
    start = 1'b0;
  endtask

  // Full operation with latency checks; leaves the bench in the done cycle.
  task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] expQ, input logic [7:0] expR,
                       input logic expDiv0, input logic expOvf);
    applyStimulus(a, b);
    if (b != 8'd0) begin
      for (int i = 1; i <= 8; i++) begin
        checkOutput($sformatf("%s run c%0d busy/done", tag, i), {busy, done}, 2'b10);
        nextCycle();
      end
    end
    checkOutput({tag, " busy/done"}, {busy, done}, 2'b01);
    checkOutput({tag, " quotient"}, quotient, expQ);
    checkOutput({tag, " remainder"}, remainder, expR);
    checkOutput({tag, " div0"}, div0, expDiv0);
    checkOutput({tag, " ovf"}, ovf, expOvf);
  endtask

  initial begin
    logic sawDone;
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b0;
    start      = 1'b0;
    dividend   = 8'd0;
    divisor    = 8'd0;

    // Reset state.
    nextCycle();
    nextCycle();
    checkOutput("reset outputs", {quotient, remainder, busy, done, div0, ovf}, 20'h0);
    @(negedge clk);
    reset = 1'b1;
    nextCycle();
    checkOutput("idle after reset", {busy, done}, 2'b00);

    // Basic operation and result hold afterwards.
    runOp("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
    nextCycle();
    checkOutput("hold done low", {busy, done}, 2'b00);
    checkOutput("hold quotient", quotient, 8'd14);
    checkOutput("hold remainder", remainder, 8'd2);

    // Max dividend, then back-to-back start during DONE.
    runOp("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0);
    runOp("5/9 b2b", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b0);

    // Divide by zero, then a normal op clears div0.
    runOp("37/0", 8'd37, 8'd0, 8'hFF, 8'd37, 1'b1, 1'b0);
    runOp("200/10", 8'd200, 8'd10, Q200_10, R200_10, 1'b0, 1'b0);

    // Start during RUN is ignored; results frozen while stepping.
    applyStimulus(8'd200, 8'd3);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("run c4 quotient frozen", quotient, Q200_10);
    checkOutput("run c4 remainder frozen", remainder, R200_10);
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    nextCycle();
    start = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      checkOutput($sformatf("ignore c%0d busy/done", i), {busy, done}, 2'b10);
      nextCycle();
    end
    checkOutput("ignore busy/done", {busy, done}, 2'b01);
    checkOutput("ignore quotient", quotient, Q200_3);
    checkOutput("ignore remainder", remainder, R200_3);

    // Asynchronous reset in the middle of RUN.
    applyStimulus(8'd200, 8'd3);
    for (int i = 0; i < 4; i++) nextCycle();
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midrun reset outputs", {quotient, remainder, busy, done, div0, ovf}, 20'h0);
    @(negedge clk);
    reset = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 12; i++) begin
      nextCycle();
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("no activity after reset", sawDone, 1'b0);
    runOp("13/13", 8'd13, 8'd13, 8'd1, 8'd0, 1'b0, 1'b0);

`ifdef DIVIDER_SIGNED_EN
    runOp("-100/7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0);
    runOp("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
    runOp("7/-2 clr ovf", 8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
